// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side streaming logic.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FLUSH
    } state_t;

    // Output buffer holds at most two words, so occupancy fits in two bits.
    localparam int OCC_W = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order word buffer: slot0 is the head, a pop shifts slot1 down,
// and a pushed word lands in the lowest slot that is free after the pop.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [OCC_W-1:0] occ_o
);

    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] occ_mid;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        occ_mid = occ_q - {1'b0, pop_i};
        if (pop_i) begin
            slot0_d = slot1_q;
        end
        if (push_i) begin
            if (occ_mid == '0) begin
                slot0_d = data_i;
            end else begin
                slot1_d = data_i;
            end
        end
        occ_d = occ_mid + {1'b0, push_i};
        if (clr_i) begin
            occ_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Slot contents are qualified by occupancy, so they need no reset.
    always_ff @(posedge clk_i) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign data_o = slot0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a 1-cycle-latency FIFO read port into a valid/ready stream with flush
// support and a running handshake counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fifo_empty_i,
    output logic             fifo_ren_o,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             flush_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [CNT_W-1:0] xfer_cnt_o,
    output logic             busy_o
);

    state_t           state_q, state_d;
    logic             inflight_q;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [OCC_W-1:0] occ, occ_nxt;
    logic [2:0]       pending;
    logic             in_flush, hs, push, pop;

    assign in_flush  = (state_q == ST_FLUSH);
    assign m_valid_o = rst_ni && (occ != '0) && !in_flush;
    assign hs        = m_valid_o && m_ready_i;
    assign pop       = hs && !flush_i;
    // Words landing while a flush is requested or in progress are discarded.
    assign push      = inflight_q && !in_flush && !flush_i;

    // Buffered plus in-flight words, less the one leaving this cycle, must
    // leave room for one more arrival.
    assign pending    = {1'b0, occ} + {2'b0, inflight_q};
    assign fifo_ren_o = rst_ni && !fifo_empty_i && !in_flush && !flush_i
                        && (pending <= (3'd1 + {2'b0, hs}));

    assign occ_nxt = flush_i ? '0 : (occ - {1'b0, pop} + {1'b0, push});
    assign busy_o  = rst_ni && (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, pop};
        case (state_q)
            ST_IDLE:   if (fifo_ren_o) state_d = ST_ACTIVE;
            ST_ACTIVE: if (occ_nxt == '0 && !fifo_ren_o) state_d = ST_IDLE;
            ST_FLUSH:  if (!flush_i && !inflight_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_FLUSH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_ren_o;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .push_i (push),
        .pop_i  (pop),
        .data_i (fifo_rdata_i),
        .data_o (m_data_o),
        .occ_o  (occ)
    );

    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an emulated FIFO, a queue-based stream model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fifo_rd_stream;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             fifo_empty_i;
    logic             fifo_ren_o;
    logic [WIDTH-1:0] fifo_rdata_i;
    logic             flush_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [WIDTH-1:0] m_data_o;
    logic [CNT_W-1:0] xfer_cnt_o;
    logic             busy_o;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .fifo_empty_i (fifo_empty_i),
        .fifo_ren_o   (fifo_ren_o),
        .fifo_rdata_i (fifo_rdata_i),
        .flush_i      (flush_i),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_data_o     (m_data_o),
        .xfer_cnt_o   (xfer_cnt_o),
        .busy_o       (busy_o)
    );

    int nvec = 0;
    int nfail = 0;

    // Emulated upstream FIFO contents
    logic [31:0] fq[$];
    bit          ren_seen = 1'b0;

    // Stream model: words the sink has yet to receive, in order
    logic [31:0] mq[$];
    bit          m_inflight = 1'b0;
    int          mstate = 0;   // 0 idle, 1 active, 2 flushing
    int          m_cnt = 0;
    bit          armed = 1'b0;

    // Observation logs for directed checks
    int          cyc = 0;
    int          first_ren = -1;
    int          ren_pulses = 0;
    int          n_ren = 0, n_valid = 0, n_busy = 0;
    logic [31:0] got[$];
    int          got_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic upd_empty();
        fifo_empty_i = (fq.size() == 0);
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + i);
        upd_empty();
    endtask

    // Advance one cycle; inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (ren_seen && fq.size() > 0) fifo_rdata_i = fq.pop_front();
        upd_empty();
    endtask

    task automatic check_seq(input string name, input logic [31:0] base, input int n);
        int gaps;
        chk({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk({name, "_word"}, got[i], base + i);
        end
        gaps = 0;
        for (int i = 1; i < got.size(); i++) begin
            if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
        end
        chk({name, "_gaps"}, gaps, 0);
    endtask

    always @(negedge clk) begin : cmp
        int occ;
        bit e_valid, e_hs, e_ren, e_busy;
        occ     = mq.size();
        e_valid = rst_ni && (mstate != 2) && (occ != 0);
        e_hs    = e_valid && m_ready_i;
        e_ren   = rst_ni && !fifo_empty_i && (mstate != 2) && !flush_i
                  && ((occ + int'(m_inflight) - int'(e_hs)) <= 1);
        e_busy  = rst_ni && (mstate != 0);
        if (armed) begin
            chk("ren", fifo_ren_o, e_ren);
            chk("valid", m_valid_o, e_valid);
            chk("busy", busy_o, e_busy);
            chk("cnt", xfer_cnt_o, m_cnt);
            if (e_valid) chk("data", m_data_o, mq[0]);
        end
        if (fifo_ren_o === 1'b1) begin
            ren_pulses++;
            n_ren++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (m_valid_o === 1'b1) n_valid++;
        if (busy_o === 1'b1) n_busy++;
        if (m_valid_o === 1'b1 && m_ready_i && !flush_i && rst_ni) begin
            got.push_back(m_data_o);
            got_cyc.push_back(cyc);
        end
        ren_seen = (fifo_ren_o === 1'b1);
        // Advance the model across the coming rising edge
        if (!rst_ni) begin
            mq.delete();
            m_inflight = 1'b0;
            mstate = 0;
            m_cnt = 0;
        end else begin
            if (flush_i) begin
                mq.delete();
                mstate = 2;
            end else begin
                if (e_hs) begin
                    void'(mq.pop_front());
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end
                if (m_inflight && mstate != 2) mq.push_back(fifo_rdata_i);
                case (mstate)
                    0: if (e_ren) mstate = 1;
                    1: if (mq.size() == 0 && !e_ren) mstate = 0;
                    default: if (!m_inflight) mstate = 0;
                endcase
            end
            m_inflight = e_ren;
        end
        cyc++;
    end

    initial begin
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        m_ready_i    = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_rdata_i = '0;
        tick();
        tick();
        armed = 1'b1;
        #1;
        chk("rst_ren", fifo_ren_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cnt", xfer_cnt_o, 0);
        rst_ni = 1'b1;
        tick();
        tick();

        // Streaming: 8 words at full rate
        first_ren = -1;
        got.delete(); got_cyc.delete();
        m_ready_i = 1'b1;
        load(32'h1, 8);
        repeat (14) tick();
        check_seq("stream", 32'h1, 8);
        if (got_cyc.size() > 0) chk("stream_latency", got_cyc[0] - first_ren, 2);
        chk("stream_cnt", xfer_cnt_o, 8);

        // Backpressure: sink stalled for 5 cycles
        m_ready_i = 1'b0;
        ren_pulses = 0;
        load(32'h11, 6);
        repeat (5) tick();
        #1;
        chk("bp_ren_pulses", ren_pulses, 2);
        chk("bp_occ", dut.occ, 2);
        chk("bp_valid", m_valid_o, 1);
        chk("bp_data", m_data_o, 32'h11);
        got.delete(); got_cyc.delete();
        m_ready_i = 1'b1;
        repeat (12) tick();
        check_seq("bp_release", 32'h11, 6);

        // Empty FIFO for 10 cycles
        n_ren = 0; n_valid = 0; n_busy = 0;
        repeat (10) tick();
        chk("empty_ren", n_ren, 0);
        chk("empty_valid", n_valid, 0);
        chk("empty_busy", n_busy, 0);

        // Flush with a buffered word and a word in flight
        got.delete(); got_cyc.delete();
        m_ready_i = 1'b0;
        load(32'h21, 6);
        tick();
        tick();
        #1;
        chk("flush_pre_occ", dut.occ, 1);
        chk("flush_pre_inflight", dut.inflight_q, 1);
        m_ready_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_valid_next", m_valid_o, 0);
        repeat (12) tick();
        check_seq("flush_resume", 32'h23, 4);
        chk("flush_cnt", xfer_cnt_o, 2);

        // Reset for one cycle mid-stream
        load(32'h31, 8);
        repeat (4) tick();
        rst_ni = 1'b0;
        got.delete(); got_cyc.delete();
        #1;
        chk("midrst_ren", fifo_ren_o, 0);
        chk("midrst_valid", m_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("midrst_cnt", xfer_cnt_o, 0);
        repeat (14) tick();
        check_seq("midrst_resume", 32'h35, 4);
        chk("midrst_cnt_after", xfer_cnt_o, 4);

        // Counter wrap: 17 handshakes on a 4-bit counter
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        got.delete(); got_cyc.delete();
        load(32'h41, 17);
        repeat (24) tick();
        chk("wrap_words", got.size(), 17);
        chk("wrap_cnt", xfer_cnt_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
